// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generation array and its sequencer.
package movegen_pkg;

  typedef logic [5:0]  sq_idx_t;
  typedef logic [63:0] bitboard_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EMIT,
    DRAIN,
    DONE
  } seq_state_t;

  // Piece codes; bit 3 carries the colour, shared with the square array.
  localparam logic [3:0] PC_K       = 4'd1;
  localparam logic [3:0] PC_Q       = 4'd2;
  localparam logic [3:0] PC_R       = 4'd3;
  localparam logic [3:0] PC_B       = 4'd4;
  localparam logic [3:0] PC_N       = 4'd5;
  localparam logic [3:0] PC_P       = 4'd6;
  localparam int         COLOUR_BIT = 3;

  // rank and file are 1-based: a1 = 0, h1 = 7, a8 = 56, h8 = 63.
  function automatic sq_idx_t sq_index(input int unsigned rank, input int unsigned file);
    return sq_idx_t'((rank - 1) * 8 + (file - 1));
  endfunction

endpackage

// File: rtl/lsb_encoder64.sv
// Lowest-set-bit encoder over a 64-square bitboard.
module lsb_encoder64
  import movegen_pkg::*;
(
  input  logic [63:0] bits,
  output logic [5:0]  idx,
  output logic        any
);

  // Scanning downwards lets the lowest set bit win the last assignment.
  always_comb begin
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (bits[i]) idx = sq_idx_t'(i);
    end
  end

  assign any = |bits;

endmodule

// File: rtl/movegen_sequencer.sv
// Walks the side-to-move's pieces, drives emit_move per source square and
// streams the captured (from, to) pairs out on a valid/ready interface.
module movegen_sequencer
  import movegen_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] i_play,
  output logic [63:0] emit_move,
  input  logic [63:0] i_target,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic [7:0]  move_count,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  seq_state_t       state;
  bitboard_t        src_mask;
  bitboard_t        tgt_mask;
  bitboard_t        tgt_enc_in;
  sq_idx_t          src;
  sq_idx_t          src_lsb;
  sq_idx_t          tgt_lsb;
  logic             src_any;
  logic             tgt_any;
  logic [CNT_W-1:0] settle_cnt;
  logic             accept;

  // The target encoder looks at the fresh response while capturing it, and
  // at the mask minus its lowest bit while draining, so the next move is
  // ready the cycle after an accept.
  assign tgt_enc_in = (state == EMIT) ? i_target : (tgt_mask & (tgt_mask - 64'd1));
  assign accept     = move_valid && move_ready;

  lsb_encoder64 u_src_enc (
    .bits (src_mask),
    .idx  (src_lsb),
    .any  (src_any)
  );

  lsb_encoder64 u_tgt_enc (
    .bits (tgt_enc_in),
    .idx  (tgt_lsb),
    .any  (tgt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_mask   <= '0;
      tgt_mask   <= '0;
      src        <= '0;
      settle_cnt <= '0;
      emit_move  <= '0;
      move_valid <= 1'b0;
      move_from  <= '0;
      move_to    <= '0;
      move_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: a non-blocking default ahead of the case keeps done a single-cycle pulse.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_mask   <= i_play;
            move_count <= '0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (!src_any) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            src        <= src_lsb;
            src_mask   <= src_mask & (src_mask - 64'd1);
            emit_move  <= bitboard_t'(1) << src_lsb;
            settle_cnt <= '0;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (settle_cnt == CNT_W'(SETTLE_CYCLES)) begin
            tgt_mask  <= i_target;
            emit_move <= '0;
            if (tgt_any) begin
              move_valid <= 1'b1;
              move_from  <= src;
              move_to    <= tgt_lsb;
              state      <= DRAIN;
            end else begin
              state <= SCAN;
            end
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (accept) begin
            tgt_mask <= tgt_enc_in;
            if (move_count != 8'hFF) move_count <= move_count + 8'd1;
            if (tgt_any) begin
              move_to <= tgt_lsb;
            end else begin
              move_valid <= 1'b0;
              state      <= SCAN;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Randomised bench for movegen_sequencer against a list-based move model.
`timescale 1ns/1ps
module tb_movegen_sequencer;
  import movegen_pkg::*;

  localparam int SETTLE = 1;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        start      = 1'b0;
  logic [63:0] i_play     = '0;
  logic [63:0] emit_move;
  logic [63:0] i_target;
  logic        move_valid;
  logic        move_ready = 1'b0;
  logic [5:0]  move_from;
  logic [5:0]  move_to;
  logic [7:0]  move_count;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  movegen_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .i_play     (i_play),
    .emit_move  (emit_move),
    .i_target   (i_target),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_from  (move_from),
    .move_to    (move_to),
    .move_count (move_count),
    .busy       (busy),
    .done       (done)
  );

  // Square-array stub: every emitting square answers with its target set.
  bitboard_t tbl [64];
  always_comb begin
    i_target = '0;
    for (int i = 0; i < 64; i++) begin
      if (emit_move[i]) i_target = i_target | tbl[i];
    end
  end

  // Observer and consumer: logs emits and accepted moves, drives move_ready.
  int          cyc       = 0;
  bitboard_t   emit_log[$];
  logic [11:0] acc_log[$];
  int          acc_cyc[$];
  int          stall_n   = 0;
  logic [11:0] stall_mv  = '0;
  int          stab_err  = 0;
  int          hold_left = 0;
  int          ready_pct = 100;
  logic        pend      = 1'b0;
  logic [11:0] pend_mv   = '0;
  logic        rn;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (emit_move != '0) emit_log.push_back(emit_move);
      if (pend && !(move_valid && {move_from, move_to} == pend_mv)) stab_err++;
      if (move_valid && hold_left > 0) begin
        rn = 1'b0;
        hold_left--;
      end else begin
        rn = (int'($urandom_range(99)) < ready_pct);
      end
      if (move_valid && rn) begin
        acc_log.push_back({move_from, move_to});
        acc_cyc.push_back(cyc);
      end
      if (move_valid && !rn) begin
        stall_n++;
        stall_mv = {move_from, move_to};
      end
      pend       = move_valid && !rn;
      pend_mv    = {move_from, move_to};
      move_ready = rn;
    end
  end

  // Reference: sources ascending, each emitting SETTLE+1 cycles, then its
  // targets ascending.
  logic [11:0] exp_mv[$];
  bitboard_t   exp_em[$];

  function automatic void model_pass(input bitboard_t play);
    exp_mv.delete();
    exp_em.delete();
    for (int s = 0; s < 64; s++) begin
      if (play[s]) begin
        for (int k = 0; k <= SETTLE; k++) exp_em.push_back(bitboard_t'(1) << s);
        for (int d = 0; d < 64; d++) begin
          if (tbl[s][d]) exp_mv.push_back({6'(s), 6'(d)});
        end
      end
    end
  endfunction

  task automatic randomize_tbl();
    for (int i = 0; i < 64; i++) begin
      bitboard_t a;
      bitboard_t b;
      bitboard_t c;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      tbl[i] = ($urandom_range(3) == 0) ? '0 : (a & b & c);
    end
  endtask

  // One full pass from start to done, compared against the model.
  task automatic run_pass(input string name, input bitboard_t play,
                          input bitboard_t alt_play, input bit restart);
    int n;
    int exp_cnt;
    bit pulsed;
    bit seen;
    n = 0;
    pulsed = 1'b0;
    seen = 1'b0;
    emit_log.delete();
    acc_log.delete();
    acc_cyc.delete();
    stall_n  = 0;
    stab_err = 0;
    model_pass(play);
    exp_cnt = (exp_mv.size() > 255) ? 255 : exp_mv.size();
    i_play = play;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    i_play = {$urandom, $urandom};
    while (n < 4000 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (restart && !pulsed && emit_move != '0) begin
          start  = 1'b1;
          i_play = alt_play;
          pulsed = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        n++;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done after %0d cycles", name, n);
    end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s done_pulse: done,busy=%b required 00", name, {done, busy});
    end
    vectors++;
    if (acc_log.size() != exp_mv.size()) begin
      miscompares++;
      $display("FAIL %s move_total: got %0d required %0d", name, acc_log.size(), exp_mv.size());
    end
    for (int i = 0; i < exp_mv.size() && i < acc_log.size(); i++) begin
      vectors++;
      if (acc_log[i] !== exp_mv[i]) begin
        miscompares++;
        $display("FAIL %s move[%0d]: got (%0d,%0d) required (%0d,%0d)", name, i,
                 acc_log[i][11:6], acc_log[i][5:0], exp_mv[i][11:6], exp_mv[i][5:0]);
      end
    end
    vectors++;
    if (emit_log.size() != exp_em.size()) begin
      miscompares++;
      $display("FAIL %s emit_cycles: got %0d required %0d", name, emit_log.size(), exp_em.size());
    end
    for (int i = 0; i < exp_em.size() && i < emit_log.size(); i++) begin
      vectors++;
      if (emit_log[i] !== exp_em[i]) begin
        miscompares++;
        $display("FAIL %s emit[%0d]: got %h required %h", name, i, emit_log[i], exp_em[i]);
      end
    end
    vectors++;
    if (move_count !== 8'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s move_count: got %0d required %0d", name, move_count, exp_cnt);
    end
    vectors++;
    if (stab_err != 0) begin
      miscompares++;
      $display("FAIL %s handshake_stable: %0d unstable cycles, required 0", name, stab_err);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({emit_move, move_valid, move_from, move_to, move_count, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: emit=%h valid=%b from=%0d to=%0d cnt=%0d busy=%b done=%b required all 0",
               emit_move, move_valid, move_from, move_to, move_count, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, move_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: busy,done,valid=%b required 000", {busy, done, move_valid});
    end
  endtask

  task automatic test_empty_pass();
    emit_log.delete();
    acc_log.delete();
    i_play = '0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL empty_cycle1: busy,done=%b required 10", {busy, done});
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b11) begin
      miscompares++;
      $display("FAIL empty_cycle2: busy,done=%b required 11", {busy, done});
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL empty_cycle3: busy,done=%b required 00", {busy, done});
    end
    vectors++;
    if (move_count !== 8'd0 || acc_log.size() != 0 || emit_log.size() != 0) begin
      miscompares++;
      $display("FAIL empty_quiet: cnt=%0d moves=%0d emits=%0d required 0 0 0",
               move_count, acc_log.size(), emit_log.size());
    end
  endtask

  task automatic test_knight();
    for (int i = 0; i < 64; i++) tbl[i] = '0;
    tbl[sq_index(1, 2)] = (bitboard_t'(1) << sq_index(3, 1)) | (bitboard_t'(1) << sq_index(3, 3));
    ready_pct = 100;
    run_pass("knight", bitboard_t'(1) << 1, '0, 1'b0);
    vectors++;
    if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 1) begin
      miscompares++;
      $display("FAIL knight_back_to_back: accepts=%0d, required 2 on consecutive cycles", acc_cyc.size());
    end
    vectors++;
    if (move_count !== 8'd2) begin
      miscompares++;
      $display("FAIL knight_count: got %0d required 2", move_count);
    end
  endtask

  task automatic test_backpressure();
    ready_pct = 100;
    hold_left = 5;
    run_pass("backpressure", bitboard_t'(1) << 1, '0, 1'b0);
    vectors++;
    if (stall_n != 5 || stall_mv !== {6'd1, 6'd16}) begin
      miscompares++;
      $display("FAIL backpressure_hold: stalls=%0d last=(%0d,%0d) required 5 at (1,16)",
               stall_n, stall_mv[11:6], stall_mv[5:0]);
    end
  endtask

  task automatic test_corners();
    for (int i = 0; i < 64; i++) tbl[i] = '0;
    tbl[63] = bitboard_t'(1) << 62;
    run_pass("corners", (bitboard_t'(1) << 63) | bitboard_t'(1), '0, 1'b0);
    vectors++;
    if (move_count !== 8'd1) begin
      miscompares++;
      $display("FAIL corners_count: got %0d required 1", move_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    for (int i = 0; i < 64; i++) tbl[i] = '0;
    tbl[1] = (bitboard_t'(1) << 16) | (bitboard_t'(1) << 18) | (bitboard_t'(1) << 20);
    ready_pct = 100;
    i_play = bitboard_t'(1) << 1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(move_valid && move_count == 8'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(move_valid && move_count == 8'd1)) begin
      miscompares++;
      $display("FAIL mid_drain_reach: valid=%b cnt=%0d required 1 and 1", move_valid, move_count);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({emit_move, move_valid, busy, move_count} !== '0) begin
      miscompares++;
      $display("FAIL mid_drain_reset: emit=%h valid=%b busy=%b cnt=%0d required all 0",
               emit_move, move_valid, busy, move_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    randomize_tbl();
    run_pass("post_reset", {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}, '0, 1'b0);
  endtask

  task automatic test_restart_ignored();
    bitboard_t a;
    randomize_tbl();
    ready_pct = 70;
    a = ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) | (bitboard_t'(1) << 10);
    run_pass("restart", a, ~a, 1'b1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 20; p++) begin
      randomize_tbl();
      ready_pct = int'($urandom_range(100, 30));
      run_pass("random", {$urandom, $urandom} & {$urandom, $urandom} &
                         {$urandom, $urandom} & {$urandom, $urandom}, '0, 1'b0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 64; i++) tbl[i] = (i < 8) ? 64'hFFFF_FFFF_FF00_0000 : '0;
    ready_pct = 100;
    run_pass("saturation", 64'h0000_0000_0000_00FF, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tbl[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_empty_pass();
    test_knight();
    test_backpressure();
    test_corners();
    test_reset_mid_drain();
    test_restart_ignored();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
